iob_ram_sp_arb: RTL

Two-requester round-robin arbiter that shares one single-port synchronous RAM (`iob_ram_sp`) between two independent masters. Each master uses a valid/ready request channel plus a read-response pulse. The arbiter grants at most one access per cycle and drives the RAM enable, write-enable, address and write data. It returns read data to the winning master with fixed latency. It sits directly in front of the RAM instance, for example where a cache data array is shared between the CPU-side and the refill/write-back side.

---
 rtl/iob_ram_sp_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/iob_ram_sp_arb.sv
// Round-robin arbiter letting two masters share one single-port RAM, with read data steered back to the winning master.
// Latency: the request reaches the RAM in the same cycle; read response arrives after 1 cycle, or 2 with IOB_RAM_SP_ARB_RDATA_REG_EN.
// Backpressure: only the winner sees ready, and the loser holds its request. At most one access is granted per cycle.
module iob_ram_sp_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,

  output logic              rsp0_rvalid_o,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp1_rvalid_o,
  output logic [DATA_W-1:0] rsp1_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic prio;
  logic rd_pend;
  logic rd_id;
  logic gnt0;
  logic gnt1;
  logic accept;
  logic win_we;

  always_comb begin
    gnt0   = ~rst_i & req0_valid_i & (~req1_valid_i | ~prio);
    gnt1   = ~rst_i & req1_valid_i & ~gnt0;
    accept = gnt0 | gnt1;
    win_we = gnt1 ? req1_we_i : req0_we_i;

    req0_ready_o = gnt0;
    req1_ready_o = gnt1;
    mem_en_o     = accept;
    mem_we_o     = accept & win_we;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (gnt1) begin
      mem_addr_o  = req1_addr_i;
      mem_wdata_o = req1_wdata_i;
    end else if (gnt0) begin
      mem_addr_o  = req0_addr_i;
      mem_wdata_o = req0_wdata_i;
    end
  end

  // prio points at the loser of the last accepted transfer, so a waiting master wins next
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio    <= 1'b0;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      if (accept) begin
        prio <= gnt0;
      end
      rd_pend <= accept & ~win_we;
      rd_id   <= gnt1;
    end
  end

  logic fire0;
  logic fire1;

  assign fire0 = rd_pend & ~rd_id;
  assign fire1 = rd_pend & rd_id;

`ifdef IOB_RAM_SP_ARB_RDATA_REG_EN
  logic              rvld0_q;
  logic              rvld1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvld0_q  <= 1'b0;
      rvld1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvld0_q <= fire0;
      rvld1_q <= fire1;
      if (fire0) begin
        rdata0_q <= mem_rdata_i;
      end
      if (fire1) begin
        rdata1_q <= mem_rdata_i;
      end
    end
  end

  assign rsp0_rvalid_o = rvld0_q & ~rst_i;
  assign rsp1_rvalid_o = rvld1_q & ~rst_i;
  assign rsp0_rdata_o  = rdata0_q;
  assign rsp1_rdata_o  = rdata1_q;
`else
  // gating with rst_i drops a read accepted just before reset
  assign rsp0_rvalid_o = fire0 & ~rst_i;
  assign rsp1_rvalid_o = fire1 & ~rst_i;
  assign rsp0_rdata_o  = mem_rdata_i;
  assign rsp1_rdata_o  = mem_rdata_i;
`endif

endmodule
